// File: rtl/core_dispatch_pkg.sv
// Shared types and default sizing for the core dispatch arbiter.
package core_dispatch_pkg;

  // Two-state dispatch FSM: arbitrate in IDLE, present the grant pulse in GRANT.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_CORES   = 4;
  localparam int DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/core_dispatch_arbiter_rr_select.sv
// Round-robin requester selector: returns a one-hot winner, searching from ptr_i upward with wrap.
module rr_select
  import core_dispatch_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int PW      = $clog2(DEFAULT_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] winner_o
);

  // Walk offsets from farthest to nearest so the request closest to the pointer wins.
  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    if (en_i) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        idx = (int'(ptr_i) + i) % NUM_REQ;
        if (req_i[idx]) begin
          winner_o      = '0;
          winner_o[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/core_dispatch_arbiter.sv
// Core dispatch arbiter: hands the lowest-index free core to one requester per two cycles
// and takes cores back on release strobes.
// Build option: define CORE_DISPATCH_RR_EN for round-robin requester selection;
// the default build uses fixed priority (lowest requester index wins).
module core_dispatch_arbiter
  import core_dispatch_pkg::*;
#(
  parameter int CORES   = DEFAULT_CORES,
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       grant,
  output logic [$clog2(CORES)-1:0] grant_core_id,
  input  logic                     core_release,
  input  logic [$clog2(CORES)-1:0] released_core_id,
  output logic [$clog2(CORES):0]   free_count,
  output logic                     all_busy,
  output logic                     release_err
);

  localparam int CW = $clog2(CORES);
  localparam int PW = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [CORES-1:0]   free_q, free_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CW-1:0]      core_id_q, core_id_d;
  logic [CW:0]        free_count_q, free_count_d;
  logic               all_busy_q, all_busy_d;
  logic               release_err_q, release_err_d;
  logic [NUM_REQ-1:0] winner;
  logic [CW-1:0]      alloc_core;
  logic               arb_en;
  logic               arb_fire;

  function automatic logic [CW-1:0] lowest_free(input logic [CORES-1:0] bm);
    logic [CW-1:0] id;
    id = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (bm[i]) id = CW'(i);
    end
    return id;
  endfunction

  function automatic logic [CW:0] popcount(input logic [CORES-1:0] bm);
    logic [CW:0] c;
    c = '0;
    for (int i = 0; i < CORES; i++) begin
      c = c + {{CW{1'b0}}, bm[i]};
    end
    return c;
  endfunction

  // Arbitration is only possible in IDLE with at least one free core; it uses the pre-edge bitmap.
  assign arb_en     = (state_q == IDLE) && (|free_q);
  assign arb_fire   = arb_en && (|req);
  assign alloc_core = lowest_free(free_q);

`ifdef CORE_DISPATCH_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_select (
    .req_i    (req),
    .en_i     (arb_en),
    .ptr_i    (ptr_q),
    .winner_o (winner)
  );

  // Encode the one-hot winner so the pointer can move just past it.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = PW'(i);
    end
    ptr_d = ptr_q;
    if (arb_fire) begin
      ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end

  // Round-robin pointer advances only when a grant is issued.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest-index active request wins.
  always_comb begin
    winner = '0;
    if (arb_en) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req[i]) begin
          winner    = '0;
          winner[i] = 1'b1;
        end
      end
    end
  end
`endif

  // Next-state: release first, then allocation, so a same-core clash resolves to the allocation.
  always_comb begin
    state_d       = IDLE;
    grant_d       = '0;
    core_id_d     = core_id_q;
    free_d        = free_q;
    release_err_d = release_err_q;
    if (core_release) begin
      if (free_q[released_core_id]) release_err_d = 1'b1;
      else                          free_d[released_core_id] = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (arb_fire) begin
          state_d            = GRANT;
          grant_d            = winner;
          core_id_d          = alloc_core;
          free_d[alloc_core] = 1'b0;
        end
      end
      GRANT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    free_count_d = popcount(free_d);
    all_busy_d   = ~|free_d;
  end

  // State and output registers; reset frees every core and forgets any in-flight grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      core_id_q     <= '0;
      free_q        <= '1;
      free_count_q  <= (CW + 1)'(CORES);
      all_busy_q    <= 1'b0;
      release_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      core_id_q     <= core_id_d;
      free_q        <= free_d;
      free_count_q  <= free_count_d;
      all_busy_q    <= all_busy_d;
      release_err_q <= release_err_d;
    end
  end

  assign grant         = grant_q;
  assign grant_core_id = core_id_q;
  assign free_count    = free_count_q;
  assign all_busy      = all_busy_q;
  assign release_err   = release_err_q;

endmodule

// File: tb/tb_core_dispatch_arbiter.sv
// Self-checking bench for core_dispatch_arbiter (default sizing: 4 cores, 4 requesters).
module tb_core_dispatch_arbiter;

  localparam int CORES   = 4;
  localparam int NUM_REQ = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] grant_core_id;
  logic       core_release = 1'b0;
  logic [1:0] released_core_id = '0;
  logic [2:0] free_count;
  logic       all_busy;
  logic       release_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  core_dispatch_arbiter #(.CORES(CORES), .NUM_REQ(NUM_REQ)) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .grant            (grant),
    .grant_core_id    (grant_core_id),
    .core_release     (core_release),
    .released_core_id (released_core_id),
    .free_count       (free_count),
    .all_busy         (all_busy),
    .release_err      (release_err)
  );

  // Reference model: set of free cores, sticky error, "grant just issued" flag, last winner.
  bit         m_free[CORES];
  bit         m_err;
  bit         m_hold;
  int         m_last;
  logic [3:0] e_grant;
  logic [1:0] e_core;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < CORES; i++) c += m_free[i];
    return c;
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, sample 1ns after the edge.
  task automatic tick(input logic [3:0] r, input logic rel, input logic [1:0] rid, input logic rst);
    bit pre[CORES];
    int core;
    int win;
    int idx;
    req = r; core_release = rel; released_core_id = rid; reset = rst;
    pre = m_free;
    e_grant = '0;
    if (rst) begin
      for (int i = 0; i < CORES; i++) m_free[i] = 1'b1;
      m_err = 0; m_hold = 0; m_last = NUM_REQ - 1; e_core = '0;
    end else begin
      core = -1;
      for (int i = CORES - 1; i >= 0; i--) if (pre[i]) core = i;
      if (rel) begin
        if (pre[rid]) m_err = 1;
        else          m_free[rid] = 1;
      end
      if (!m_hold && r != 0 && core >= 0) begin
        win = -1;
`ifdef CORE_DISPATCH_RR_EN
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (m_last + k) % NUM_REQ;
          if (r[idx] && win < 0) win = idx;
        end
`else
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (r[i]) win = i;
`endif
        m_free[core] = 0;
        e_grant[win] = 1'b1;
        e_core = 2'(core);
        m_last = win;
        m_hold = 1;
      end else begin
        m_hold = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(4'b0000, 1'b0, 2'd0, 1'b1);
    tick(4'b0000, 1'b0, 2'd0, 1'b1);
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    tests++; if (grant_core_id !== 2'd0) begin fails++; $display("FAIL reset_core_id got=%0d exp=0", grant_core_id); end
    tests++; if (free_count !== 3'd4) begin fails++; $display("FAIL reset_free_count got=%0d exp=4", free_count); end
    tests++; if (all_busy !== 1'b0) begin fails++; $display("FAIL reset_all_busy got=%b exp=0", all_busy); end
    tests++; if (release_err !== 1'b0) begin fails++; $display("FAIL reset_release_err got=%b exp=0", release_err); end
  endtask

  task automatic test_single_grant();
    tick(4'b0000, 1'b0, 2'd0, 1'b1);
    tick(4'b0001, 1'b0, 2'd0, 1'b0);
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL single_grant got=%b exp=0001", grant); end
    tests++; if (grant_core_id !== 2'd0) begin fails++; $display("FAIL single_core got=%0d exp=0", grant_core_id); end
    tests++; if (free_count !== 3'd3) begin fails++; $display("FAIL single_free_count got=%0d exp=3", free_count); end
    tick(4'b0000, 1'b0, 2'd0, 1'b0);
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL single_pulse got=%b exp=0000", grant); end
  endtask

  task automatic test_fill_and_release();
    tick(4'b0000, 1'b0, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(4'(1 << k), 1'b0, 2'd0, 1'b0);
      tests++; if (grant !== 4'(1 << k)) begin fails++; $display("FAIL fill_grant%0d got=%b exp=%b", k, grant, 4'(1 << k)); end
      tests++; if (grant_core_id !== 2'(k)) begin fails++; $display("FAIL fill_core%0d got=%0d exp=%0d", k, grant_core_id, k); end
      tick(4'b0000, 1'b0, 2'd0, 1'b0);
    end
    tests++; if (all_busy !== 1'b1) begin fails++; $display("FAIL fill_all_busy got=%b exp=1", all_busy); end
    tests++; if (free_count !== 3'd0) begin fails++; $display("FAIL fill_free_count got=%0d exp=0", free_count); end
    for (int k = 0; k < 3; k++) begin
      tick(4'b0001, 1'b0, 2'd0, 1'b0);
      tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL empty_wait%0d got=%b exp=0000", k, grant); end
    end
    tick(4'b0001, 1'b1, 2'd2, 1'b0);
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL release_edge_grant got=%b exp=0000", grant); end
    tests++; if (free_count !== 3'd1) begin fails++; $display("FAIL release_edge_count got=%0d exp=1", free_count); end
    tick(4'b0001, 1'b0, 2'd0, 1'b0);
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL waited_grant got=%b exp=0001", grant); end
    tests++; if (grant_core_id !== 2'd2) begin fails++; $display("FAIL waited_core got=%0d exp=2", grant_core_id); end
    tests++; if (all_busy !== 1'b1) begin fails++; $display("FAIL waited_all_busy got=%b exp=1", all_busy); end
    tick(4'b0000, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_grant_order();
    logic [3:0] pending;
    int got;
    tick(4'b0000, 1'b0, 2'd0, 1'b1);
    pending = 4'b1111;
    got = 0;
    for (int c = 0; c < 16 && got < 4; c++) begin
      tick(pending, 1'b0, 2'd0, 1'b0);
      if (grant !== 4'b0000) begin
        tests++; if (grant !== 4'(1 << got)) begin fails++; $display("FAIL order_grant%0d got=%b exp=%b", got, grant, 4'(1 << got)); end
        pending = pending & ~grant;
        got++;
      end
    end
    tests++; if (got !== 4) begin fails++; $display("FAIL order_count got=%0d exp=4", got); end
    tick(4'b0000, 1'b1, 2'd0, 1'b1);
    tick(4'b1111, 1'b0, 2'd0, 1'b0);
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL held_first got=%b exp=0001", grant); end
    tick(4'b1111, 1'b0, 2'd0, 1'b0);
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL held_gap got=%b exp=0000", grant); end
    tick(4'b1111, 1'b0, 2'd0, 1'b0);
`ifdef CORE_DISPATCH_RR_EN
    tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL held_second got=%b exp=0010", grant); end
`else
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL held_second got=%b exp=0001", grant); end
`endif
    tests++; if (grant_core_id !== 2'd1) begin fails++; $display("FAIL held_second_core got=%0d exp=1", grant_core_id); end
    tick(4'b0000, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_release_err();
    tick(4'b0000, 1'b0, 2'd0, 1'b1);
    tick(4'b0000, 1'b1, 2'd1, 1'b0);
    tests++; if (release_err !== 1'b1) begin fails++; $display("FAIL relerr_set got=%b exp=1", release_err); end
    tests++; if (free_count !== 3'd4) begin fails++; $display("FAIL relerr_count got=%0d exp=4", free_count); end
    tick(4'b0000, 1'b0, 2'd0, 1'b0);
    tests++; if (release_err !== 1'b1) begin fails++; $display("FAIL relerr_sticky got=%b exp=1", release_err); end
  endtask

  task automatic test_simultaneous();
    tick(4'b0000, 1'b0, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(4'b0001, 1'b0, 2'd0, 1'b0);
      tick(4'b0000, 1'b0, 2'd0, 1'b0);
    end
    tick(4'b0000, 1'b1, 2'd1, 1'b0);
    tick(4'b0000, 1'b1, 2'd2, 1'b0);
    tests++; if (free_count !== 3'd2) begin fails++; $display("FAIL simul_pre_count got=%0d exp=2", free_count); end
    tick(4'b0001, 1'b1, 2'd0, 1'b0);
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL simul_grant got=%b exp=0001", grant); end
    tests++; if (grant_core_id !== 2'd1) begin fails++; $display("FAIL simul_core got=%0d exp=1", grant_core_id); end
    tests++; if (free_count !== 3'd2) begin fails++; $display("FAIL simul_count got=%0d exp=2", free_count); end
    tests++; if (release_err !== 1'b0) begin fails++; $display("FAIL simul_err got=%b exp=0", release_err); end
    tick(4'b0000, 1'b0, 2'd0, 1'b0);
    tick(4'b0001, 1'b0, 2'd0, 1'b0);
    tests++; if (grant_core_id !== 2'd0) begin fails++; $display("FAIL simul_freed_core got=%0d exp=0", grant_core_id); end
    tick(4'b0000, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_reset_in_grant();
    tick(4'b0000, 1'b0, 2'd0, 1'b1);
    tick(4'b0010, 1'b0, 2'd0, 1'b0);
    tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL rig_grant got=%b exp=0010", grant); end
    tick(4'b0000, 1'b0, 2'd0, 1'b1);
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL rig_drop got=%b exp=0000", grant); end
    tests++; if (free_count !== 3'd4) begin fails++; $display("FAIL rig_count got=%0d exp=4", free_count); end
    tick(4'b0010, 1'b0, 2'd0, 1'b0);
    tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL rig_idle_grant got=%b exp=0010", grant); end
    tests++; if (grant_core_id !== 2'd0) begin fails++; $display("FAIL rig_idle_core got=%0d exp=0", grant_core_id); end
    tick(4'b0000, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rel;
    logic [1:0] rid;
    logic       rst;
    tick(4'b0000, 1'b0, 2'd0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      r   = 4'($urandom_range(0, 15));
      rel = ($urandom_range(0, 2) == 0);
      rid = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) == 0);
      tick(r, rel, rid, rst);
      tests++; if (grant !== e_grant) begin fails++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, grant, e_grant); end
      if (e_grant != 4'b0000) begin
        tests++; if (grant_core_id !== e_core) begin fails++; $display("FAIL rand_core c=%0d got=%0d exp=%0d", c, grant_core_id, e_core); end
      end
      tests++; if (free_count !== 3'(m_count())) begin fails++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, free_count, m_count()); end
      tests++; if (all_busy !== (m_count() == 0)) begin fails++; $display("FAIL rand_all_busy c=%0d got=%b exp=%b", c, all_busy, m_count() == 0); end
      tests++; if (release_err !== m_err) begin fails++; $display("FAIL rand_release_err c=%0d got=%b exp=%b", c, release_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_fill_and_release();
    test_grant_order();
    test_release_err();
    test_simultaneous();
    test_reset_in_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_dispatch_arbiter.md
CORE_DISPATCH_ARBITER -- requirements
Module: core_dispatch_arbiter

Interface
- REQ-001: Parameter CORES, default 4, is the number of cores in the pool; it is a power of two and at least 2.
- REQ-002: Parameter NUM_REQ, default 4, is the number of requesters sharing the pool; it is at least 2.
- REQ-003: Port clk, input, 1 bit, is the single clock; all logic SHALL be rising-edge.
- REQ-004: Port reset, input, 1 bit, is the reset, synchronous and active-high.
- REQ-005: Port req, input, NUM_REQ bits, is a level request per requester.
- REQ-006: Port grant, output, NUM_REQ bits, is a one-hot, one-cycle grant pulse.
- REQ-007: Port grant_core_id, output, $clog2(CORES) bits, is the core assigned; it is valid only while grant is nonzero.
- REQ-008: Port core_release, input, 1 bit, is a single-cycle release strobe.
- REQ-009: Port released_core_id, input, $clog2(CORES) bits, is the core being released; it is sampled only with core_release.
- REQ-010: Port free_count, output, $clog2(CORES)+1 bits, is the number of currently free cores.
- REQ-011: Port all_busy, output, 1 bit, is high when free_count == 0.
- REQ-012: Port release_err, output, 1 bit, is a sticky flag for the release of an already-free core.

Function
- REQ-013: The block SHALL keep a free bitmap of CORES bits, where a 1 means the core is free.
- REQ-014: The FSM SHALL have two states, IDLE and GRANT.
- REQ-015: In IDLE, when any req bit is high and the bitmap is nonzero, the block SHALL select one requester and the lowest-index free core, then go to GRANT on the next edge.
  - At that same edge, grant SHALL be registered to the winner's one-hot and grant_core_id to the core.
  - At that same edge, the core's bitmap bit SHALL be cleared.
- REQ-016: Grant latency SHALL be exactly 1 cycle from the first sampled req (IDLE, free core present) to grant high.
- REQ-017: In GRANT, the block SHALL drive grant for exactly one cycle, then return to IDLE with grant = 0; no new arbitration happens in GRANT.
  - A granted requester deasserts req in the cycle after grant.
  - The maximum grant rate is one per 2 cycles.
- REQ-018: With an empty bitmap, no grant SHALL issue, the FSM SHALL stay in IDLE, and requests SHALL wait without loss.
- REQ-019: A core_release whose core is busy SHALL set its bitmap bit on the same edge.
- REQ-020: A core_release whose core is already free SHALL leave the bitmap unchanged and set release_err, which stays set until reset.
- REQ-021: On a simultaneous release and IDLE arbitration, selection SHALL use the pre-edge bitmap.
  - The release and the allocation SHALL both apply on the same edge.
  - If both target the same core (impossible unless release_err), the release is treated as an error and the allocation wins.
- REQ-022: free_count and all_busy SHALL be registered and consistent with the bitmap after each edge.
- REQ-023: Internal core id arithmetic SHALL be $clog2(CORES) bits; free_count SHALL never exceed CORES nor underflow.

Reset
- REQ-024: On reset the block SHALL set state = IDLE, grant = 0, grant_core_id = 0, bitmap all ones, free_count = CORES, all_busy = 0, release_err = 0, and the round-robin pointer = 0.
- REQ-025: Reset asserted in GRANT SHALL drop grant on the next edge.
  - In-flight allocations are forgotten and all cores become free.

Configuration
- REQ-026: With macro CORE_DISPATCH_RR_EN defined, requester selection SHALL be round-robin.
  - The search starts at the index after the last winner; the pointer updates only on grant.
- REQ-027: Without CORE_DISPATCH_RR_EN, requester selection SHALL be fixed priority, lowest index first.
- REQ-028: Ports, latency and core selection SHALL be identical in both builds.

Structure
- REQ-029: Package core_dispatch_pkg SHALL hold the FSM state enum (IDLE, GRANT) and the default CORES and NUM_REQ localparams.
- REQ-030: Requester selection SHALL live in sub-module rr_select, which takes req, an enable and the pointer and returns a one-hot winner.
  - In the fixed-priority build, rr_select SHALL be bypassed by a priority encoder.
- REQ-031: Lowest-free-core selection SHALL be a combinational function in the top module.

Verification
- REQ-032: Reset, then req=4'b0001 held -> grant=0001 and core 0 one cycle later; free_count=3.
- REQ-033: Four sequential requests with no release -> cores 0,1,2,3 granted, all_busy=1; a fifth req gets no grant until a release of core 2, after which the grant gives core 2.
- REQ-034: RR build, req=4'b1111 held with each requester dropping req after its grant -> grant order 0,1,2,3; fixed-priority build with the same stimulus -> grants go to 0,1,2,3 only because winners drop; with req constant 1111, requester 0 is regranted each time.
- REQ-035: Release of core 1 while it is free -> release_err=1, free_count unchanged.
- REQ-036: Release of core 0 on the same edge as an IDLE arbitration with cores 0 and 3 busy (bitmap 0110) -> allocation takes core 1, core 0 is freed, free_count unchanged.
- REQ-037: Reset asserted in GRANT -> grant=0 on the next edge, free_count=CORES, state IDLE.
